adder_share_ctrl: RTL and testbench
===================================

Name: adder_share_ctrl

Overview:
Round-robin controller that shares one combinational WIDTH-bit adder (operands A, B; result Sum) between NREQ requesters. It registers the winning requester's operands onto the shared adder inputs and captures the sum after one settle cycle. It returns the sum with the requester ID over a valid/ready result channel. It sits between client blocks and the single adder instance in the top level.

Parameters:
WIDTH, 4, operand and sum width in bits.
NREQ, 4, number of requesters; must be at least 2.
IDW, $clog2(NREQ), requester ID width. Derived; do not override.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
req  in  NREQ  per-requester request; held with the operands until granted.
a_in  in  NREQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
b_in  in  NREQ*WIDTH  packed operand B; same packing as a_in.
gnt  out  NREQ  one-hot grant, high for exactly one cycle.
add_a  out  WIDTH  registered operand driven to the shared adder A.
add_b  out  WIDTH  registered operand driven to the shared adder B.
add_sum  in  WIDTH  Sum returned by the shared adder.
res_valid  out  1  result available.
res_id  out  IDW  index of the requester that owns the result.
res_sum  out  WIDTH  captured sum.
res_ready  in  1  result consumer accepts the result.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state IDLE. gnt, add_a, add_b, res_valid, res_id and res_sum all go to 0. Round-robin pointer ptr goes to 0. Reset applies from any state and discards any operation in flight.
- State IDLE:
  - If req is non-zero, the winner is the first set bit searching ptr, ptr+1, ... and wrapping modulo NREQ.
  - On that edge: gnt[winner]<=1, add_a/add_b <= the winner's operands, id<=winner, state<=CALC.
  - If req is zero, nothing changes.
- State CALC:
  - gnt is high during this cycle and is cleared on the next edge.
  - The adder settles during this cycle.
  - On the edge: res_sum<=add_sum, res_id<=id, res_valid<=1, state<=RESP.
- State RESP:
  - res_valid, res_id and res_sum are held stable. gnt stays 0. req is ignored.
  - When res_ready=1 at an edge: res_valid<=0, ptr<=(id+1) mod NREQ, state<=IDLE.
- Latency and throughput:
  - req sampled at edge k gives gnt high for cycle k..k+1.
  - res_valid rises at edge k+1; with res_ready held high it falls at edge k+2.
  - Minimum of 3 cycles per operation.
- Requester contract:
  - The requester keeps req and operands stable until it sees gnt.
  - It drops req, or presents the next operation, in the cycle after gnt.
  - A req dropped before grant is silently withdrawn.
- Arithmetic: sum is modulo 2^WIDTH; a wrap is not an error (for example F+2=1 at WIDTH=4).
- add_a and add_b hold their last values outside CALC; the adder output is only sampled in CALC.
- res_ready is ignored outside RESP.

Optional Feature:
Macro ADDER_SHARE_CARRY_EN.
- Defined: adds an output port res_carry (1 bit, reset 0). It is captured in CALC as (add_sum < add_a), which is the unsigned carry-out. It is held in RESP alongside res_sum.
- Undefined: no res_carry port and no comparator logic.

Decomposition:
- Package adder_share_pkg holds:
  - the state encoding (IDLE=2'd0, CALC=2'd1, RESP=2'd2);
  - the default WIDTH and NREQ constants.
- Sub-module rr_pick (combinational), parameter NREQ.
  - Inputs: req, ptr.
  - Outputs: any, winner index.
  - Implemented as a rotate, then priority-encode, then un-rotate.
- The controller FSM, operand muxing and result registers stay in adder_share_ctrl.

Test Plan:
Parameters for all scenarios: WIDTH=4, NREQ=4.
1. rst high for 2 cycles, then req=0001, A0=3, B0=4 -> gnt=0001 for one cycle after edge k; res_valid=1, res_id=0, res_sum=7 after edge k+1; with res_ready=1, res_valid=0 after edge k+2.
2. req=0010, A1=F, B1=2 -> res_sum=1 and res_id=1; with ADDER_SHARE_CARRY_EN, res_carry=1. Then A1=1, B1=2 -> res_sum=3, res_carry=0.
3. req=1111 held continuously, res_ready=1 -> grant order 0, 1, 2, 3, 0 with one grant every 3 cycles; res_sum checked per ID with A_i=i, B_i=2*i giving 0, 3, 6, 9.
4. Backpressure: res_ready=0 for 5 cycles during RESP with req=0100 pending -> res_valid, res_id and res_sum are stable and gnt stays 0. After res_ready=1, gnt=0100 follows 1 cycle after res_valid falls.
5. rst asserted while in CALC (grant to requester 2 in flight) -> after that edge all outputs are 0 and no result is produced. Then req=0101 -> requester 0 is granted first (ptr=0).
6. req=1000 withdrawn before grant while the controller is in RESP -> no grant ever issued to requester 3; the controller returns to IDLE and stays idle.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared constants for the adder-sharing controller: FSM state encoding and
// default sizing. Optional carry output is enabled with ADDER_SHARE_CARRY_EN.
package adder_share_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NREQ_DEF  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/adder_share_ctrl_rr_pick.sv
// Combinational round-robin picker: the first set request at or after the
// pointer wins, searching upward and wrapping around.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            any_o,
  output logic [IDW-1:0]  winner_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                off;
  int                idx;

  // Rotate so the pointer position lands at bit 0, take the lowest set bit,
  // then add the pointer back to recover the absolute index.
  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[NREQ-1:0];
    off = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    idx = int'(ptr_i) + off;
    if (idx >= NREQ) idx = idx - NREQ;
    any_o    = |req_i;
    winner_o = IDW'(idx);
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one external adder between NREQ requesters.
// Define ADDER_SHARE_CARRY_EN to add the res_carry output.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int NREQ  = NREQ_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_sum,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH-1:0]      res_sum,
`ifdef ADDER_SHARE_CARRY_EN
  output logic                  res_carry,
`endif
  input  logic                  res_ready
);

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             res_valid_q, res_valid_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
`ifdef ADDER_SHARE_CARRY_EN
  logic             res_carry_q, res_carry_d;
`endif

  logic             pickAny;
  logic [IDW-1:0]   pickIdx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .any_o    (pickAny),
    .winner_o (pickIdx)
  );

  // gnt defaults low so the one-cycle grant pulse clears on the CALC edge.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    gnt_d       = '0;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;
`ifdef ADDER_SHARE_CARRY_EN
    res_carry_d = res_carry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pickAny) begin
          gnt_d   = NREQ'(1) << pickIdx;
          add_a_d = a_in[int'(pickIdx)*WIDTH +: WIDTH];
          add_b_d = b_in[int'(pickIdx)*WIDTH +: WIDTH];
          id_d    = pickIdx;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        res_sum_d   = add_sum;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
`ifdef ADDER_SHARE_CARRY_EN
        // A wrapped unsigned sum is smaller than either operand.
        res_carry_d = (add_sum < add_a_q);
`endif
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          ptr_d       = (int'(id_q) == NREQ - 1) ? '0 : id_q + IDW'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sum_q   <= '0;
`ifdef ADDER_SHARE_CARRY_EN
      res_carry_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
`ifdef ADDER_SHARE_CARRY_EN
      res_carry_q <= res_carry_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;
`ifdef ADDER_SHARE_CARRY_EN
  assign res_carry = res_carry_q;
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl: directed scenarios then random traffic.
// Carry checks are compiled in when ADDER_SHARE_CARRY_EN is defined.
module tb_adder_share_ctrl;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in, b_in;
  logic [N-1:0]   gnt;
  logic [W-1:0]   add_a, add_b, add_sum;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [W-1:0]   res_sum;
  logic           res_ready;
`ifdef ADDER_SHARE_CARRY_EN
  logic           res_carry;
`endif

  adder_share_ctrl #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_sum   (res_sum),
`ifdef ADDER_SHARE_CARRY_EN
    .res_carry (res_carry),
`endif
    .res_ready (res_ready)
  );

  // The shared adder itself lives outside the controller.
  assign add_sum = add_a + add_b;

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int sum;
    int carry;
  } exp_t;

  exp_t     expQ[$];
  int       checks = 0;
  int       errors = 0;
  int       ptrModel = 0;
  int       opA[N];
  int       opB[N];
  logic [N-1:0] pendMask = '0;
  exp_t     popped;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    req = pendMask;
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = W'(opA[i]);
      b_in[i*W +: W] = W'(opB[i]);
    end
  endtask

  // Drive and observe just after the rising edge; the monitor samples on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int modelWinner(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptrModel + k) % N]) return (ptrModel + k) % N;
    end
    return -1;
  endfunction

  task automatic waitGrant(input bit randReady, output int cycles, output logic [N-1:0] g);
    cycles = 0;
    g = '0;
    while (cycles < 150) begin
      step();
      cycles++;
      if (gnt != '0) begin
        g = gnt;
        break;
      end
      if (randReady) res_ready = ($urandom_range(0, 3) != 0);
    end
    if (g == '0) checkOutput("grant_timeout", 0, 1);
  endtask

  task automatic issueAndCheck(input bit randReady, input bit keepWinner, output int cycles);
    int w;
    int s;
    logic [N-1:0] g;
    exp_t e;
    w = modelWinner(pendMask);
    waitGrant(randReady, cycles, g);
    checkOutput("gnt", int'(g), 1 << w);
    checkOutput("add_a", int'(add_a), opA[w]);
    checkOutput("add_b", int'(add_b), opB[w]);
    s = opA[w] + opB[w];
    e.id = w;
    e.sum = s % 16;
    e.carry = (s > 15) ? 1 : 0;
    expQ.push_back(e);
    ptrModel = (w + 1) % N;
    if (!keepWinner) pendMask[w] = 1'b0;
    applyStimulus();
    step();
    if (randReady) res_ready = ($urandom_range(0, 3) != 0);
    checkOutput("gnt_one_cycle", int'(gnt), 0);
  endtask

  task automatic applyReset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    expQ.delete();
    ptrModel = 0;
  endtask

  // Monitor: every accepted result is compared with the oldest expected one.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        popped = expQ.pop_front();
        checkOutput("res_id", int'(res_id), popped.id);
        checkOutput("res_sum", int'(res_sum), popped.sum);
`ifdef ADDER_SHARE_CARRY_EN
        checkOutput("res_carry", int'(res_carry), popped.carry);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int cyc;
    logic [N-1:0] g;
    rst = 1'b1;
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      opA[i] = 0;
      opB[i] = 0;
    end
    applyStimulus();
    applyReset(2);

    checkOutput("reset_gnt", int'(gnt), 0);
    checkOutput("reset_add_a", int'(add_a), 0);
    checkOutput("reset_add_b", int'(add_b), 0);
    checkOutput("reset_res_valid", int'(res_valid), 0);
    checkOutput("reset_res_id", int'(res_id), 0);
    checkOutput("reset_res_sum", int'(res_sum), 0);

    // Basic latency: 3 + 4 from requester 0.
    $display("[TB] scenario 1: single request latency");
    res_ready = 1'b1;
    opA[0] = 3; opB[0] = 4; pendMask = 4'b0001;
    applyStimulus();
    issueAndCheck(1'b0, 1'b0, cyc);
    checkOutput("s1_res_valid_high", int'(res_valid), 1);
    step();
    checkOutput("s1_res_valid_low", int'(res_valid), 0);

    // Wrapping sum then a non-wrapping follow-up from requester 1.
    $display("[TB] scenario 2: wrap and carry");
    opA[1] = 15; opB[1] = 2; pendMask = 4'b0010;
    applyStimulus();
    issueAndCheck(1'b0, 1'b0, cyc);
    opA[1] = 1; opB[1] = 2; pendMask = 4'b0010;
    applyStimulus();
    issueAndCheck(1'b0, 1'b0, cyc);
    step();
    step();

    // All four held high: strict rotation, one grant every three cycles.
    $display("[TB] scenario 3: full contention");
    applyReset(1);
    for (int i = 0; i < N; i++) begin
      opA[i] = i;
      opB[i] = 2 * i;
    end
    pendMask = 4'b1111;
    applyStimulus();
    for (int n = 0; n < 5; n++) begin
      issueAndCheck(1'b0, 1'b1, cyc);
      if (n > 0) checkOutput("s3_grant_spacing", cyc, 2);
    end
    pendMask = '0;
    applyStimulus();
    step();
    step();

    // Backpressure with requester 2 waiting, then reset while it is in CALC.
    $display("[TB] scenario 4/5: backpressure and reset in flight");
    res_ready = 1'b0;
    opA[0] = $urandom_range(0, 15); opB[0] = $urandom_range(0, 15);
    pendMask = 4'b0001;
    applyStimulus();
    issueAndCheck(1'b0, 1'b0, cyc);
    opA[2] = 5; opB[2] = 6; pendMask = 4'b0100;
    applyStimulus();
    repeat (5) begin
      step();
      checkOutput("s4_hold_valid", int'(res_valid), 1);
      checkOutput("s4_hold_id", int'(res_id), 0);
      checkOutput("s4_hold_sum", int'(res_sum), (opA[0] + opB[0]) % 16);
      checkOutput("s4_hold_gnt", int'(gnt), 0);
    end
    res_ready = 1'b1;
    step();
    checkOutput("s4_valid_fall", int'(res_valid), 0);
    checkOutput("s4_no_early_gnt", int'(gnt), 0);
    step();
    checkOutput("s4_gnt_after", int'(gnt), 4'b0100);
    rst = 1'b1;
    pendMask = '0;
    applyStimulus();
    step();
    rst = 1'b0;
    expQ.delete();
    ptrModel = 0;
    checkOutput("s5_gnt", int'(gnt), 0);
    checkOutput("s5_add_a", int'(add_a), 0);
    checkOutput("s5_add_b", int'(add_b), 0);
    checkOutput("s5_res_valid", int'(res_valid), 0);
    checkOutput("s5_res_id", int'(res_id), 0);
    checkOutput("s5_res_sum", int'(res_sum), 0);
    repeat (3) begin
      step();
      checkOutput("s5_no_result", int'(res_valid), 0);
    end
    opA[0] = 7; opB[0] = 1; opA[2] = 9; opB[2] = 9;
    pendMask = 4'b0101;
    applyStimulus();
    issueAndCheck(1'b0, 1'b0, cyc);
    issueAndCheck(1'b0, 1'b0, cyc);
    step();
    step();

    // Requester 3 withdraws while the controller is busy in RESP.
    $display("[TB] scenario 6: withdrawn request");
    res_ready = 1'b0;
    opA[1] = 12; opB[1] = 3; pendMask = 4'b0010;
    applyStimulus();
    issueAndCheck(1'b0, 1'b0, cyc);
    pendMask = 4'b1000;
    applyStimulus();
    repeat (3) begin
      step();
      checkOutput("s6_gnt_busy", int'(gnt), 0);
    end
    pendMask = '0;
    applyStimulus();
    res_ready = 1'b1;
    repeat (10) begin
      step();
      checkOutput("s6_gnt_idle", int'(gnt), 0);
    end
    checkOutput("s6_res_valid", int'(res_valid), 0);

    // Random traffic with random backpressure.
    $display("[TB] random phase");
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pendMask[i] && $urandom_range(0, 1) == 1) begin
          opA[i] = $urandom_range(0, 15);
          opB[i] = $urandom_range(0, 15);
          pendMask[i] = 1'b1;
        end
      end
      if (pendMask == '0) begin
        g = N'(1) << $urandom_range(0, N - 1);
        for (int i = 0; i < N; i++) begin
          if (g[i]) begin
            opA[i] = $urandom_range(0, 15);
            opB[i] = $urandom_range(0, 15);
          end
        end
        pendMask = g;
      end
      applyStimulus();
      issueAndCheck(1'b1, 1'b0, cyc);
    end
    pendMask = '0;
    applyStimulus();
    res_ready = 1'b1;
    repeat (6) step();
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
